// File: rtl/sd_decimator.sv
// Sigma-delta demodulator: 3rd-order CIC decimator (R = 2^DEC_LOG2) turning a
// 1-bit pulse-density stream into 16-bit signed PCM samples.
module sd_decimator #(
  parameter int DEC_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        din_en,
  input  logic        din,
  output logic [15:0] dout,
  output logic        dout_valid
);

  localparam int W  = 3*DEC_LOG2 + 1;
  localparam int SH = 3*DEC_LOG2 - 16;
  localparam logic [W-1:0]          HALF    = W'(1) << (3*DEC_LOG2 - 1);
  localparam logic signed [W-1:0]   YMAX    = 32767;
  localparam logic [DEC_LOG2-1:0]   PH_LAST = '1;
  localparam logic [DEC_LOG2-1:0]   PH_ONE  = 1;

  logic [W-1:0]          int1_q, int2_q, int3_q;
  logic [W-1:0]          snap_q, snap_d1_q, c1_d1_q, c2_d1_q;
  logic [DEC_LOG2-1:0]   phase_q;
  logic                  snap_flag_q;
  logic [1:0]            warm_q;
  logic [15:0]           dout_q;
  logic                  valid_q;

  logic [W-1:0]          c1, c2, c3, ctr;
  logic signed [W-1:0]   ysh;
  logic [15:0]           dout_d;

  // Comb stage is evaluated every cycle but only consumed on the cycle after a snapshot.
  always_comb begin
    c1     = snap_q - snap_d1_q;
    c2     = c1 - c1_d1_q;
    c3     = c2 - c2_d1_q;
    ctr    = c3 - HALF;
    ysh    = $signed(ctr) >>> SH;
    dout_d = ysh[15:0];
    // Only the all-ones window reaches +32768; the negative end cannot overflow.
    if (ysh > YMAX) dout_d = 16'h7fff;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      int1_q      <= '0;
      int2_q      <= '0;
      int3_q      <= '0;
      snap_q      <= '0;
      snap_d1_q   <= '0;
      c1_d1_q     <= '0;
      c2_d1_q     <= '0;
      phase_q     <= '0;
      snap_flag_q <= 1'b0;
      warm_q      <= 2'd0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      snap_flag_q <= 1'b0;
      valid_q     <= 1'b0;
      if (din_en) begin
        int1_q  <= int1_q + {{(W-1){1'b0}}, din};
        int2_q  <= int2_q + int1_q;
        int3_q  <= int3_q + int2_q;
        phase_q <= phase_q + PH_ONE;
        if (phase_q == PH_LAST) begin
          snap_q      <= int3_q;
          snap_flag_q <= 1'b1;
        end
      end
      if (snap_flag_q) begin
        snap_d1_q <= snap_q;
        c1_d1_q   <= c1;
        c2_d1_q   <= c2;
        // First three snapshots only prime the comb delay line.
        if (warm_q == 2'd3) begin
          dout_q  <= dout_d;
          valid_q <= 1'b1;
        end else begin
          warm_q <= warm_q + 2'd1;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_sd_decimator.sv
// Directed bench for sd_decimator at R=512: DC levels, warm-up, gapped strobe,
// mid-period reset and integrator wrap-around.
module tb_sd_decimator;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        din_en = 1'b0;
  logic        din = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;

  sd_decimator #(.DEC_LOG2(9)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_en     (din_en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int   nvec = 0, nerr = 0;
  int   ncyc, nbits, npulse, first_cyc, last_cyc, skip, exp_dout, exp_gap;
  bit   chk_on;
  logic prev_vld;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  // One clock: drive inputs, advance past the edge, then look at the outputs.
  task automatic cyc(input logic en, input logic b);
    din_en = en;
    din    = b;
    @(posedge clk);
    #1;
    ncyc++;
    if (en) nbits++;
    if (dout_valid) begin
      npulse++;
      chk("vlen", int'(prev_vld), 0);
      if (first_cyc < 0) first_cyc = ncyc;
      if (last_cyc >= 0) chk("gap", ncyc - last_cyc, exp_gap);
      last_cyc = ncyc;
      if (skip > 0) skip--;
      else if (chk_on) chk("dout", int'($signed(dout)), exp_dout);
    end
    prev_vld = dout_valid;
  endtask

  // Pattern bits follow the accepted-bit count; non-strobed cycles get noise on din.
  task automatic run(input int n, input int stride, input logic [3:0] p);
    for (int i = 0; i < n; i++) begin
      logic en, b;
      en = ((i % stride) == 0);
      b  = en ? p[3 - (nbits % 4)] : 1'($urandom);
      cyc(en, b);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_vld", int'(dout_valid), 0);
    repeat (3) begin
      din_en = 1'b1;
      din    = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("rst_hold", int'(dout), 0);
    din_en    = 1'b0;
    rstn      = 1'b1;
    ncyc      = 0;
    nbits     = 0;
    npulse    = 0;
    first_cyc = -1;
    last_cyc  = -1;
    skip      = 0;
    prev_vld  = 1'b0;
  endtask

  initial begin
    chk_on  = 1'b1;
    exp_gap = 512;
    #2;

    // all ones: saturates, first pulse the cycle after bit 2048
    do_reset();
    exp_dout = 32767;
    run(4096, 1, 4'b1111);
    chk("ones_np", npulse, 4);
    chk("ones_first", first_cyc, 2049);

    // all zeros
    do_reset();
    exp_dout = -32768;
    run(4096, 1, 4'b0000);
    chk("zero_np", npulse, 4);

    // 50% density
    do_reset();
    exp_dout = 0;
    run(4096, 1, 4'b1010);
    chk("alt_np", npulse, 4);

    // 75% across integrator wrap, then switch to 25% on a period boundary
    do_reset();
    exp_dout = 16384;
    run(30720, 1, 4'b1110);
    chk("wrap_np", npulse, 56);
    exp_dout = -16384;
    skip = 3;  // pending old-window pulse plus two transition pulses
    run(2560, 1, 4'b1000);
    chk("sw_np", npulse, 61);

    // strobe every 3rd cycle
    do_reset();
    exp_dout = 16384;
    exp_gap  = 1536;
    run(10752, 3, 4'b1110);
    chk("gap_np", npulse, 4);
    chk("gap_first", first_cyc, 6143);

    // reset 200 bits into a period, full warm-up must restart
    do_reset();
    exp_dout = 16384;
    exp_gap  = 512;
    run(2760, 1, 4'b1110);
    chk("mid_np", npulse, 2);
    chk("mid_dout", int'($signed(dout)), 16384);
    do_reset();
    run(2100, 1, 4'b1110);
    chk("mid_np2", npulse, 1);
    chk("mid_first", first_cyc, 2049);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
